// File: rtl/placement_wl_eval_if.sv
// -----------------------------------------------------------------------------
// placement_wl_eval_if
// Memory-side bus of the wirelength evaluator: the edge ROM pair (source and
// sink node ids share one index) and the posX/posY RAM pair (share one node
// address). Both read channels carry one-cycle read pulses. Data is valid two
// cycles after the pulse and is held until the next read.
//   reE / addrE        : edge ROM read enable / edge index
//   doutEA / doutEB    : source / sink node id
//   reP / addrP        : position RAM read enable / node id
//   doutPX / doutPY    : node X / node Y (signed)
// master = evaluator, slave = memory model / memory wrapper.
// -----------------------------------------------------------------------------
interface placement_wl_eval_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              reE;
  logic [CNT_W-1:0]  addrE;
  logic [DATA_W-1:0] doutEA;
  logic [DATA_W-1:0] doutEB;
  logic              reP;
  logic [DATA_W-1:0] addrP;
  logic [DATA_W-1:0] doutPX;
  logic [DATA_W-1:0] doutPY;

  modport master (
    output reE, addrE, reP, addrP,
    input  doutEA, doutEB, doutPX, doutPY
  );

  modport slave (
    input  reE, addrE, reP, addrP,
    output doutEA, doutEB, doutPX, doutPY
  );
endinterface

// File: rtl/placement_wl_eval.sv
// -----------------------------------------------------------------------------
// placement_wl_eval
// Walks the edge list after placement and reports routing cost:
//   sum      : sum over edges of (|dx|+|dy|-1), wraps modulo 2^DATA_W
//   max_len  : largest |dx|+|dy| seen
//   long_cnt : edges with |dx|+|dy| > 1 (saturating)
//   coll_cnt : edges whose distinct endpoints share a cell (saturating)
//   err      : sticky, some endpoint coordinate is UNPLACED
// Each edge takes a fixed 8 cycles. done pulses one cycle when results are
// valid; results hold until the next accepted start.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   start_i     : evaluation request, honoured only in IDLE
//   n_edge_i    : edge count, latched on start
//   busy_o      : run in progress
//   done_o      : one-cycle completion pulse
//   sum_o, max_len_o, long_cnt_o, coll_cnt_o, err_o : results
//   mem         : edge ROM / position RAM bus (master side)
// -----------------------------------------------------------------------------
module placement_wl_eval #(
  parameter int                DATA_W   = 32,
  parameter int                CNT_W    = 8,
  parameter logic [DATA_W-1:0] UNPLACED = {DATA_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         n_edge_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic signed [DATA_W-1:0] sum_o,
  output logic signed [DATA_W-1:0] max_len_o,
  output logic [CNT_W-1:0]         long_cnt_o,
  output logic [CNT_W-1:0]         coll_cnt_o,
  output logic                     err_o,
  placement_wl_eval_if.master      mem
);

  localparam logic [CNT_W-1:0]         CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]         CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]         CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0]        DATA_ZERO = {DATA_W{1'b0}};
  localparam logic signed [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    E_REQ   = 4'd1,
    E_WAIT  = 4'd2,
    PA_REQ  = 4'd3,
    PA_WAIT = 4'd4,
    PB_REQ  = 4'd5,
    PB_WAIT = 4'd6,
    CALC    = 4'd7,
    ACC     = 4'd8,
    FIN     = 4'd9
  } state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           n_q;
  logic [CNT_W-1:0]           idx_q;
  logic [DATA_W-1:0]          a_q;
  logic [DATA_W-1:0]          b_q;
  logic signed [DATA_W-1:0]   xa_q;
  logic signed [DATA_W-1:0]   ya_q;
  logic signed [DATA_W-1:0]   xb_q;
  logic signed [DATA_W-1:0]   yb_q;
  logic signed [DATA_W-1:0]   dist_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       reE_q;
  logic [CNT_W-1:0]           addrE_q;
  logic                       reP_q;
  logic [DATA_W-1:0]          addrP_q;
  logic signed [DATA_W-1:0]   sum_q;
  logic signed [DATA_W-1:0]   max_len_q;
  logic [CNT_W-1:0]           long_q;
  logic [CNT_W-1:0]           coll_q;
  logic                       err_q;

  logic [CNT_W-1:0]           idx_inc_s;
  logic                       unplaced_s;

  // |p - q| in two's complement
  function automatic logic signed [DATA_W-1:0] abs_diff(
    input logic signed [DATA_W-1:0] p,
    input logic signed [DATA_W-1:0] q
  );
    logic signed [DATA_W-1:0] d;
    d = p - q;
    abs_diff = d[DATA_W-1] ? (DATA_ZERO - d) : d;
  endfunction

  assign idx_inc_s  = idx_q + CNT_ONE;
  assign unplaced_s = (xa_q == UNPLACED) || (ya_q == UNPLACED) ||
                      (xb_q == UNPLACED) || (yb_q == UNPLACED);

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sum_o      = sum_q;
  assign max_len_o  = max_len_q;
  assign long_cnt_o = long_q;
  assign coll_cnt_o = coll_q;
  assign err_o      = err_q;

  assign mem.reE    = reE_q;
  assign mem.addrE  = addrE_q;
  assign mem.reP    = reP_q;
  // The source id arrives in the very cycle its position read is issued, so
  // the address is forwarded straight from the ROM output during PA_REQ.
  assign mem.addrP  = (state_q == PA_REQ) ? mem.doutEA : addrP_q;

  // Evaluation FSM with all outputs and result accumulators registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      n_q       <= CNT_ZERO;
      idx_q     <= CNT_ZERO;
      a_q       <= DATA_ZERO;
      b_q       <= DATA_ZERO;
      xa_q      <= DATA_ZERO;
      ya_q      <= DATA_ZERO;
      xb_q      <= DATA_ZERO;
      yb_q      <= DATA_ZERO;
      dist_q    <= DATA_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      reE_q     <= 1'b0;
      addrE_q   <= CNT_ZERO;
      reP_q     <= 1'b0;
      addrP_q   <= DATA_ZERO;
      sum_q     <= DATA_ZERO;
      max_len_q <= DATA_ZERO;
      long_q    <= CNT_ZERO;
      coll_q    <= CNT_ZERO;
      err_q     <= 1'b0;
    end else begin
      // pulses default low; states below raise them for exactly one cycle
      reE_q  <= 1'b0;
      reP_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_q       <= n_edge_i;
            idx_q     <= CNT_ZERO;
            sum_q     <= DATA_ZERO;
            max_len_q <= DATA_ZERO;
            long_q    <= CNT_ZERO;
            coll_q    <= CNT_ZERO;
            err_q     <= 1'b0;
            if (n_edge_i == CNT_ZERO) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= E_REQ;
              busy_q  <= 1'b1;
              reE_q   <= 1'b1;
              addrE_q <= CNT_ZERO;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        E_REQ: begin
          state_q <= E_WAIT;
        end
        E_WAIT: begin
          state_q <= PA_REQ;
          reP_q   <= 1'b1;
        end
        PA_REQ: begin
          a_q     <= mem.doutEA;
          b_q     <= mem.doutEB;
          addrP_q <= mem.doutEA;
          state_q <= PA_WAIT;
        end
        PA_WAIT: begin
          state_q <= PB_REQ;
          reP_q   <= 1'b1;
          addrP_q <= b_q;
        end
        PB_REQ: begin
          xa_q    <= mem.doutPX;
          ya_q    <= mem.doutPY;
          state_q <= PB_WAIT;
        end
        PB_WAIT: begin
          state_q <= CALC;
        end
        CALC: begin
          xb_q    <= mem.doutPX;
          yb_q    <= mem.doutPY;
          dist_q  <= abs_diff(xa_q, mem.doutPX) + abs_diff(ya_q, mem.doutPY);
          state_q <= ACC;
        end
        ACC: begin
          if (unplaced_s) begin
            err_q <= 1'b1;
          end else if (dist_q == DATA_ZERO) begin
            // same cell: a collision only when the endpoints differ
            if (a_q != b_q) begin
              if (coll_q != CNT_MAX) begin
                coll_q <= coll_q + CNT_ONE;
              end else begin
                coll_q <= coll_q;
              end
            end else begin
              coll_q <= coll_q;
            end
          end else begin
            sum_q <= sum_q + (dist_q - DATA_ONE);
            if (dist_q > max_len_q) begin
              max_len_q <= dist_q;
            end else begin
              max_len_q <= max_len_q;
            end
            if ((dist_q > DATA_ONE) && (long_q != CNT_MAX)) begin
              long_q <= long_q + CNT_ONE;
            end else begin
              long_q <= long_q;
            end
          end
          idx_q <= idx_inc_s;
          if (idx_inc_s == n_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= E_REQ;
            reE_q   <= 1'b1;
            addrE_q <= idx_inc_s;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_placement_wl_eval.sv
// -----------------------------------------------------------------------------
// tb_placement_wl_eval
// Directed bench for placement_wl_eval. Holds small edge/position memories
// with the two-cycle read latency of the real ROM/RAMs and runs one task per
// scenario, each comparing outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_placement_wl_eval;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [7:0]  n_edge_i;
  logic        busy_o;
  logic        done_o;
  logic signed [31:0] sum_o;
  logic signed [31:0] max_len_o;
  logic [7:0]  long_cnt_o;
  logic [7:0]  coll_cnt_o;
  logic        err_o;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int rd_e_cnt = 0;
  int rd_p_cnt = 0;

  logic [31:0] ea_mem [16];
  logic [31:0] eb_mem [16];
  logic [31:0] px_mem [16];
  logic [31:0] py_mem [16];
  logic        e_p1;
  logic [3:0]  e_a1;
  logic        p_p1;
  logic [3:0]  p_a1;

  placement_wl_eval_if #(.DATA_W(32), .CNT_W(8)) mem_if ();

  placement_wl_eval #(.DATA_W(32), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .n_edge_i   (n_edge_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sum_o      (sum_o),
    .max_len_o  (max_len_o),
    .long_cnt_o (long_cnt_o),
    .coll_cnt_o (coll_cnt_o),
    .err_o      (err_o),
    .mem        (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: request sampled at edge t, data driven at edge t+1,
  // i.e. valid in the second cycle after the read pulse and held after.
  always @(posedge clk) begin
    e_p1 <= mem_if.reE;
    e_a1 <= mem_if.addrE[3:0];
    p_p1 <= mem_if.reP;
    p_a1 <= mem_if.addrP[3:0];
    if (e_p1 === 1'b1) begin
      mem_if.doutEA <= ea_mem[e_a1];
      mem_if.doutEB <= eb_mem[e_a1];
    end
    if (p_p1 === 1'b1) begin
      mem_if.doutPX <= px_mem[p_a1];
      mem_if.doutPY <= py_mem[p_a1];
    end
    if (mem_if.reE === 1'b1) rd_e_cnt <= rd_e_cnt + 1;
    if (mem_if.reP === 1'b1) rd_p_cnt <= rd_p_cnt + 1;
  end

  task automatic set_edge(input int i, input int a, input int b);
    ea_mem[i] = 32'(a);
    eb_mem[i] = 32'(b);
  endtask

  task automatic set_node(input int i, input int x, input int y);
    px_mem[i] = 32'(x);
    py_mem[i] = 32'(y);
  endtask

  // Issues start at edge 0 and steps 8*n+6 cycles; cycle k is sampled 1ns
  // after edge k-1. Optionally re-pulses start (with another n) at dup_at.
  task automatic run_eval(input int n, input int dup_at, output int done_cyc,
                          output int done_cnt, output int re_cnt, output int rp_cnt,
                          output int busy_lo);
    int e0;
    int p0;
    @(posedge clk); #1;
    start_i  = 1'b1;
    n_edge_i = 8'(n);
    e0 = rd_e_cnt;
    p0 = rd_p_cnt;
    @(posedge clk); #1;
    start_i  = 1'b0;
    n_edge_i = 8'd0;
    done_cyc = -1;
    done_cnt = 0;
    busy_lo  = 0;
    for (int cyc = 1; cyc <= 8 * n + 6; cyc++) begin
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if ((cyc <= 8 * n) && (busy_o !== 1'b1)) busy_lo++;
      if (cyc == dup_at) begin
        start_i  = 1'b1;
        n_edge_i = 8'd3;
      end else begin
        start_i  = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    re_cnt  = rd_e_cnt - e0;
    rp_cnt  = rd_p_cnt - p0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start_i = 1'b0;
    n_edge_i = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if ({busy_o, done_o, err_o} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy_o, done_o, err_o}); else pass_cnt++;
    chk_cnt++; if ({mem_if.reE, mem_if.reP} !== 2'b00) $display("FAIL reset_re: got %b expected 00", {mem_if.reE, mem_if.reP}); else pass_cnt++;
    chk_cnt++; if ({mem_if.addrE, mem_if.addrP} !== 40'd0) $display("FAIL reset_addr: got %0h expected 0", {mem_if.addrE, mem_if.addrP}); else pass_cnt++;
    chk_cnt++; if ({sum_o, max_len_o, long_cnt_o, coll_cnt_o} !== 80'd0) $display("FAIL reset_results: got %0h expected 0", {sum_o, max_len_o, long_cnt_o, coll_cnt_o}); else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_single;
    int dc, dn, re, rp, bl;
    set_edge(0, 0, 1);
    set_node(0, 0, 0);
    set_node(1, 2, 3);
    run_eval(1, 0, dc, dn, re, rp, bl);
    chk_cnt++; if (dc !== 9) $display("FAIL single_done_cycle: got %0d expected 9", dc); else pass_cnt++;
    chk_cnt++; if (sum_o !== 32'sd4) $display("FAIL single_sum: got %0d expected 4", sum_o); else pass_cnt++;
    chk_cnt++; if (max_len_o !== 32'sd5) $display("FAIL single_max: got %0d expected 5", max_len_o); else pass_cnt++;
    chk_cnt++; if ({long_cnt_o, coll_cnt_o, err_o} !== {8'd1, 8'd0, 1'b0}) $display("FAIL single_counts: got long=%0d coll=%0d err=%b expected 1 0 0", long_cnt_o, coll_cnt_o, err_o); else pass_cnt++;
    chk_cnt++; if ({re, rp} !== {32'd1, 32'd2}) $display("FAIL single_reads: got reE=%0d reP=%0d expected 1 2", re, rp); else pass_cnt++;
    chk_cnt++; if ({dn, bl} !== {32'd1, 32'd0}) $display("FAIL single_handshake: got dones=%0d busy_low=%0d expected 1 0", dn, bl); else pass_cnt++;
  endtask

  task automatic test_adjacent;
    int dc, dn, re, rp, bl;
    set_node(2, 0, 0);
    set_node(3, 1, 0);
    set_node(4, 1, 1);
    set_node(5, 0, 1);
    set_edge(0, 2, 3);
    set_edge(1, 3, 4);
    set_edge(2, 4, 5);
    run_eval(3, 0, dc, dn, re, rp, bl);
    chk_cnt++; if (dc !== 25) $display("FAIL adj_done_cycle: got %0d expected 25", dc); else pass_cnt++;
    chk_cnt++; if ({sum_o, max_len_o} !== {32'sd0, 32'sd1}) $display("FAIL adj_sum_max: got sum=%0d max=%0d expected 0 1", sum_o, max_len_o); else pass_cnt++;
    chk_cnt++; if ({long_cnt_o, coll_cnt_o, err_o} !== 17'd0) $display("FAIL adj_counts: got long=%0d coll=%0d err=%b expected 0 0 0", long_cnt_o, coll_cnt_o, err_o); else pass_cnt++;
    chk_cnt++; if ({re, rp} !== {32'd3, 32'd6}) $display("FAIL adj_reads: got reE=%0d reP=%0d expected 3 6", re, rp); else pass_cnt++;
  endtask

  task automatic test_negative;
    int dc, dn, re, rp, bl;
    set_node(11, -3, 2);
    set_node(12, 4, -5);
    set_edge(0, 11, 12);
    run_eval(1, 0, dc, dn, re, rp, bl);
    chk_cnt++; if ({sum_o, max_len_o} !== {32'sd13, 32'sd14}) $display("FAIL neg_sum_max: got sum=%0d max=%0d expected 13 14", sum_o, max_len_o); else pass_cnt++;
  endtask

  task automatic test_unplaced;
    int dc, dn, re, rp, bl;
    set_node(6, 5, 5);
    set_node(7, 2, 4);
    set_node(8, -1, 0);
    set_edge(0, 6, 7);
    set_edge(1, 6, 8);
    run_eval(2, 0, dc, dn, re, rp, bl);
    chk_cnt++; if (err_o !== 1'b1) $display("FAIL unplaced_err: got %b expected 1", err_o); else pass_cnt++;
    chk_cnt++; if ({sum_o, max_len_o, long_cnt_o} !== {32'sd3, 32'sd4, 8'd1}) $display("FAIL unplaced_results: got sum=%0d max=%0d long=%0d expected 3 4 1", sum_o, max_len_o, long_cnt_o); else pass_cnt++;
  endtask

  task automatic test_zero;
    int dc, dn, re, rp, bl;
    run_eval(0, 0, dc, dn, re, rp, bl);
    chk_cnt++; if (dc !== 1) $display("FAIL zero_done_cycle: got %0d expected 1", dc); else pass_cnt++;
    chk_cnt++; if ({sum_o, max_len_o, long_cnt_o, coll_cnt_o, err_o} !== 81'd0) $display("FAIL zero_results: got sum=%0d max=%0d long=%0d coll=%0d err=%b expected all 0", sum_o, max_len_o, long_cnt_o, coll_cnt_o, err_o); else pass_cnt++;
    chk_cnt++; if ({re, rp} !== 64'd0) $display("FAIL zero_reads: got reE=%0d reP=%0d expected 0 0", re, rp); else pass_cnt++;
  endtask

  task automatic test_collision;
    int dc, dn, re, rp, bl;
    set_node(9, 1, 1);
    set_node(10, 1, 1);
    set_edge(0, 9, 10);
    run_eval(1, 0, dc, dn, re, rp, bl);
    chk_cnt++; if ({coll_cnt_o, sum_o, long_cnt_o} !== {8'd1, 32'sd0, 8'd0}) $display("FAIL coll_distinct: got coll=%0d sum=%0d long=%0d expected 1 0 0", coll_cnt_o, sum_o, long_cnt_o); else pass_cnt++;
    set_edge(0, 9, 9);
    run_eval(1, 0, dc, dn, re, rp, bl);
    chk_cnt++; if ({coll_cnt_o, sum_o, max_len_o, err_o} !== 73'd0) $display("FAIL coll_selfloop: got coll=%0d sum=%0d max=%0d err=%b expected 0 0 0 0", coll_cnt_o, sum_o, max_len_o, err_o); else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    int dones;
    int e0;
    set_node(0, 0, 0);
    set_node(1, 2, 3);
    for (int i = 0; i < 4; i++) set_edge(i, 0, 1);
    dones = 0;
    @(posedge clk); #1;
    start_i  = 1'b1;
    n_edge_i = 8'd4;
    @(posedge clk); #1;
    start_i  = 1'b0;
    for (int cyc = 1; cyc < 12; cyc++) begin
      if (done_o === 1'b1) dones++;
      @(posedge clk); #1;
    end
    chk_cnt++; if ({busy_o, sum_o} !== {1'b1, 32'sd4}) $display("FAIL midrun_pre: got busy=%b sum=%0d expected 1 4", busy_o, sum_o); else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk_cnt++; if ({busy_o, done_o, err_o, mem_if.reE, mem_if.reP} !== 5'b0) $display("FAIL midrun_flags: got %b expected 00000", {busy_o, done_o, err_o, mem_if.reE, mem_if.reP}); else pass_cnt++;
    chk_cnt++; if ({mem_if.addrE, mem_if.addrP} !== 40'd0) $display("FAIL midrun_addr: got %0h expected 0", {mem_if.addrE, mem_if.addrP}); else pass_cnt++;
    chk_cnt++; if ({sum_o, max_len_o, long_cnt_o, coll_cnt_o} !== 80'd0) $display("FAIL midrun_results: got sum=%0d max=%0d long=%0d coll=%0d expected 0", sum_o, max_len_o, long_cnt_o, coll_cnt_o); else pass_cnt++;
    e0 = rd_e_cnt + rd_p_cnt;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done_o === 1'b1) dones++;
      @(posedge clk); #1;
    end
    chk_cnt++; if (dones !== 0) $display("FAIL midrun_no_done: got %0d expected 0", dones); else pass_cnt++;
    chk_cnt++; if ((rd_e_cnt + rd_p_cnt - e0) !== 0) $display("FAIL midrun_no_reads: got %0d expected 0", rd_e_cnt + rd_p_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int dc, dn, re, rp, bl;
    set_edge(0, 0, 1);
    set_node(0, 0, 0);
    set_node(1, 2, 3);
    run_eval(1, 5, dc, dn, re, rp, bl);
    chk_cnt++; if ({dc, dn} !== {32'd9, 32'd1}) $display("FAIL b2b_done: got cycle=%0d count=%0d expected 9 1", dc, dn); else pass_cnt++;
    chk_cnt++; if ({sum_o, max_len_o, long_cnt_o} !== {32'sd4, 32'sd5, 8'd1}) $display("FAIL b2b_results: got sum=%0d max=%0d long=%0d expected 4 5 1", sum_o, max_len_o, long_cnt_o); else pass_cnt++;
    chk_cnt++; if ({re, rp, busy_o} !== {32'd1, 32'd2, 1'b0}) $display("FAIL b2b_idle: got reE=%0d reP=%0d busy=%b expected 1 2 0", re, rp, busy_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_adjacent();
    test_negative();
    test_unplaced();
    test_zero();
    test_collision();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/placement_wl_eval.md
Name: placement_wl_eval

Overview:
- Downstream stage of the grid placer: runs once placement has written every node's X/Y into the position RAMs.
- Walks the edge list and reports the routing cost of the placement: total wirelength as the sum over edges of (|dx|+|dy|-1), the longest edge, the number of edges needing routing hops, collisions, and unplaced nodes.
- Results feed the top-level report and later iterative-refinement stages.

Parameters:
- DATA_W, 32, width of memory data, coordinates and result registers (signed).
- CNT_W, 8, width of n_edge and of edge index/counters.
- UNPLACED, -1, coordinate value marking an unplaced node.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to evaluate; sampled only in IDLE
- n_edge  in  CNT_W  number of edges to evaluate; latched at start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse, results valid
- reE  out  1  read enable to edge ROMs (ea and eb share the index)
- addrE  out  CNT_W  edge index
- doutEA  in  DATA_W  source node id
- doutEB  in  DATA_W  sink node id
- reP  out  1  read enable to posX and posY RAMs
- addrP  out  DATA_W  node id
- doutPX  in  DATA_W  node X (signed)
- doutPY  in  DATA_W  node Y (signed)
- sum  out  DATA_W  total cost
- max_len  out  DATA_W  largest |dx|+|dy|
- long_cnt  out  CNT_W  edges with |dx|+|dy| > 1
- coll_cnt  out  CNT_W  edges with distinct endpoints at the same cell
- err  out  1  sticky: some endpoint is unplaced

Behaviour:
- Memory timing:
  - read asserted in cycle t; data valid and sampled in cycle t+2, held until the next read.
  - read enables are one-cycle pulses, low in every other cycle.
- Reset (reset==0 at a clock edge):
  - state=IDLE, counters=0.
  - All outputs 0: busy, done, reE, reP, addrE, addrP, sum, max_len, long_cnt, coll_cnt, err.
  - Applies mid-evaluation too: the run is aborted, no done pulse, memories not read further.
- IDLE:
  - On start=1: latch n_edge; clear sum, max_len, long_cnt, coll_cnt, err; busy=1; idx=0.
  - If n_edge==0, go to FIN; else go to E_REQ.
  - start is ignored while busy.
- Per edge, fixed 8 cycles:
  - E_REQ: reE=1, addrE=idx.
  - E_WAIT: no action.
  - PA_REQ: latch a=doutEA, b=doutEB; reP=1, addrP=doutEA.
  - PA_WAIT: no action.
  - PB_REQ: latch xa,ya; reP=1, addrP=b.
  - PB_WAIT: no action.
  - CALC: latch xb,yb; adx=|xa-xb|, ady=|ya-yb| as signed DATA_W; dist=adx+ady.
  - ACC: update results per the edge-cost rules below; idx++; if idx==n_edge go to FIN, else E_REQ.
- Edge-cost rules (applied in ACC):
  - If any of xa,ya,xb,yb == UNPLACED: err=1; edge contributes nothing.
  - Else if dist==0 and a!=b: coll_cnt++; cost 0.
  - Else if dist==0 and a==b: self-loop; cost 0; not a collision.
  - Else: sum += dist-1; max_len = max(max_len, dist); long_cnt++ if dist>1.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Results hold until the next accepted start.
- Latency: with start accepted at edge 0, done is high in cycle 8*n_edge+1 (n_edge=0 gives cycle 1).
- Arithmetic: signed two's complement; sum wraps modulo 2^DATA_W; counters saturate at all-ones.

Test Plan:
- 1 edge, node0 at (0,0), node1 at (2,3), n_edge=1, start -> done in cycle 9; sum=4, max_len=5, long_cnt=1, coll_cnt=0, err=0.
- 3 edges, each with endpoints on adjacent cells -> done in cycle 25; sum=0, max_len=1, long_cnt=0.
- 2 edges, the second with node X = -1 -> err=1; sum and max_len reflect only edge 0.
- Edge between distinct nodes both at (1,1) -> coll_cnt=1, sum=0. Self-loop a==b -> coll_cnt=0, sum=0.
- n_edge=0 -> done in cycle 1; all results 0; reE and reP never asserted.
- reset=0 at cycle 12 of a 4-edge run -> all outputs 0 next cycle, no done. start pulsed while busy in a fresh run -> ignored; results match the single run.
